// File: rtl/median_seq.sv
// Sequential median-of-9 filter: nine pixels are loaded serially, then one
// shared max/min comparator runs max-extraction passes over a rotating register file.
module median_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMP
    } state_t;

    state_t state, state_nx;

    logic [8:0][WIDTH-1:0] r;
    logic [3:0]            count;
    logic [2:0]            pass;
    logic [3:0]            cycle;
    logic [WIDTH-1:0]      mx;
    logic [WIDTH-1:0]      mn;

    logic load_en;
    logic load_last;
    logic cmp_en;
    logic disc_en;
    logic done;

    median_seq_mce #(.WIDTH(WIDTH)) u_mce (
        .A   (r[7]),
        .B   (r[8]),
        .MAX (mx),
        .MIN (mn)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (DSI)       state_nx = LOAD;
            LOAD:    if (load_last) state_nx = COMP;
            COMP:    if (done)      state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Control outputs; cycle 8 only occurs in passes 0..3 because pass 4 ends at cycle 7
    always_comb begin
        load_en   = 1'b0;
        load_last = 1'b0;
        cmp_en    = 1'b0;
        disc_en   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                load_en = DSI;
            end
            LOAD: begin
                load_en   = DSI;
                load_last = DSI && (count == 4'd8);
            end
            COMP: begin
                disc_en = (cycle == 4'd8);
                cmp_en  = (cycle != 4'd8);
                done    = (cycle == 4'd7) && (pass == 3'd4);
            end
            default: ;
        endcase
    end

    // Sample counter and pass/cycle sequencer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
            pass  <= '0;
            cycle <= '0;
        end else begin
            if (load_last) begin
                count <= '0;
            end else if (load_en) begin
                count <= (state == IDLE) ? 4'd1 : count + 4'd1;
            end

            if (load_last || done) begin
                pass  <= '0;
                cycle <= '0;
            end else if (disc_en) begin
                pass  <= pass + 3'd1;
                cycle <= '0;
            end else if (cmp_en) begin
                cycle <= cycle + 4'd1;
            end
        end
    end

    // Register file: R0..R7 form a ring through the comparator, R8 accumulates the maximum
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r <= '0;
        end else if (load_en) begin
            r[8:1] <= r[7:0];
            r[0]   <= DI;
        end else if (cmp_en) begin
            r[8]   <= mx;
            r[7:1] <= r[6:0];
            r[0]   <= mn;
        end else if (disc_en) begin
            r[8]   <= r[7];
            r[7:1] <= r[6:0];
            r[0]   <= '0;
        end
    end

    // Result register and one-cycle strobe
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            DO  <= '0;
            DSO <= 1'b0;
        end else begin
            DSO <= done;
            if (done) begin
                DO <= mx;
            end
        end
    end

endmodule

module median_seq_mce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] MIN
);

    always_comb begin
        if (A > B) begin
            MAX = A;
            MIN = B;
        end else begin
            MAX = B;
            MIN = A;
        end
    end

endmodule

// File: tb/tb_median_seq.sv
// Directed and random checks of the sequential median-of-9 filter.
module tb_median_seq;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;

    int n_checks   = 0;
    int n_fail     = 0;
    int dso_cnt    = 0;
    int exp_dso    = 0;
    int consec_err = 0;
    bit prev_dso   = 1'b0;
    int snap;

    logic [7:0] blk [9];

    median_seq #(.WIDTH(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .DO   (DO),
        .DSO  (DSO)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DSO) begin
            dso_cnt++;
            if (prev_dso) consec_err++;
        end
        prev_dso = DSO;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        DI  = v;
        DSI = 1'b1;
        tick();
        DSI = 1'b0;
    endtask

    // Returns at the first sample point where DSO is high; optional DI/DSI noise while computing
    task automatic wait_result(input bit noise, output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (DSO) begin
                lat = k;
                break;
            end
            if (noise) begin
                DSI = k[0];
                DI  = k[1] ? 8'hFF : 8'h00;
            end
        end
        DSI = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [7:0] exp,
                             input int gap_after, input int gap_len, input bit noise);
        int lat;
        for (int i = 0; i < 9; i++) begin
            feed(blk[i]);
            if (i == gap_after - 1) repeat (gap_len) tick();
        end
        wait_result(noise, lat);
        check({tag, "_lat"}, lat, 44);
        check(tag, 32'(DO), 32'(exp));
        exp_dso++;
    endtask

    task automatic async_reset();
        #3 nRST = 1'b0;
        #1;
        check("rst_do", 32'(DO), 0);
        check("rst_dso", 32'(DSO), 0);
        #2 nRST = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] s [9];
        logic [7:0] t;

        nRST = 1'b0;
        DI   = '0;
        DSI  = 1'b0;
        #12;
        check("reset_do", 32'(DO), 0);
        check("reset_dso", 32'(DSO), 0);
        tick();
        nRST = 1'b1;
        tick();

        // Ascending block, then strobe width and hold
        blk = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        run_block("asc", 8'd5, 0, 0, 1'b0);
        tick();
        check("asc_dso_low", 32'(DSO), 0);
        check("asc_hold1", 32'(DO), 5);
        repeat (5) tick();
        check("asc_hold2", 32'(DO), 5);

        // Descending, all-equal, ties at extremes; noise during compute
        blk = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_block("desc", 8'd5, 0, 0, 1'b1);
        blk = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        run_block("equal", 8'd200, 0, 0, 1'b1);
        blk = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0};
        run_block("zeros5", 8'd0, 0, 0, 1'b0);
        blk = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        run_block("ones5", 8'd255, 0, 0, 1'b1);

        // Stall after 4th sample plus compute-time noise
        tick();
        snap = dso_cnt;
        blk = '{8'd10, 8'd50, 8'd30, 8'd90, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60};
        run_block("stall", 8'd50, 4, 3, 1'b1);
        repeat (3) tick();
        check("stall_dso_once", dso_cnt - snap, 1);

        // Reset mid-load, then mid-compute (pass 2)
        for (int i = 0; i < 5; i++) feed(8'd100 + 8'(i));
        async_reset();
        snap = dso_cnt;
        blk = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd140, 8'd160, 8'd180};
        for (int i = 0; i < 9; i++) feed(blk[i]);
        repeat (20) tick();
        async_reset();
        repeat (50) tick();
        check("abort_no_dso", dso_cnt - snap, 0);
        check("abort_do", 32'(DO), 0);
        blk = '{8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd1, 8'd7, 8'd7, 8'd7};
        run_block("after_rst", 8'd3, 0, 0, 1'b0);

        // Back-to-back: first sample driven in the DSO cycle
        blk = '{8'd100, 8'd20, 8'd60, 8'd80, 8'd40, 8'd0, 8'd255, 8'd90, 8'd70};
        run_block("b2b", 8'd70, 0, 0, 1'b0);

        // Random blocks against a reference sort
        for (int b = 0; b < 1000; b++) begin
            for (int i = 0; i < 9; i++) begin
                blk[i] = 8'($urandom_range(0, 255));
                s[i]   = blk[i];
            end
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8 - i; j++)
                    if (s[j] > s[j+1]) begin
                        t      = s[j];
                        s[j]   = s[j+1];
                        s[j+1] = t;
                    end
            run_block("rand", s[4], 0, 0, 1'b0);
        end

        repeat (4) tick();
        check("dso_total", dso_cnt, exp_dso);
        check("dso_consec", consec_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
